// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with write bypass, pending-write scoreboard and sequential clear engine
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear_req,
    output logic            ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_pending,
    output logic            rs2_pending,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            flush
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state;
    logic [AW-1:0]       clearPtr;
    logic [NUM_REGS-1:0] pendingBits;
    logic [NUM_REGS-1:0] pendingNext;
    logic [XLEN-1:0]     regMem [NUM_REGS];

    // Writes and issues aimed at a hardwired x0 are discarded.
    logic wrKeep;
    logic issKeep;
    logic wrHits1;
    logic wrHits2;

    assign wrKeep  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign issKeep = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));
    assign wrHits1 = wr_en && (wr_addr == rs1_addr);
    assign wrHits2 = wr_en && (wr_addr == rs2_addr);

    // Clear/ready state machine: sweep every entry once, then open the ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR;
            clearPtr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clearPtr <= clearPtr + 1'b1;
                    if (clearPtr == AW'(NUM_REGS - 1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        clearPtr <= '0;
                        ready    <= 1'b0;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    clearPtr <= '0;
                    ready    <= 1'b0;
                end
            endcase
        end
    end

    // Next pending vector: flush drops all, writeback releases, issue sets last so it wins.
    always_comb begin
        pendingNext = flush ? '0 : pendingBits;
        if (wr_en) begin
            pendingNext[wr_addr] = 1'b0;
        end
        if (issKeep) begin
            pendingNext[iss_addr] = 1'b1;
        end
    end

    // Pending scoreboard; held at zero while the clear engine runs and on a clear request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pendingBits <= '0;
        end else if (state == CLEAR || clear_req) begin
            pendingBits <= '0;
        end else begin
            pendingBits <= pendingNext;
        end
    end

    // Storage array without reset so it can map to RAM; the sweep provides the zeroing.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regMem[clearPtr] <= '0;
        end else if (wrKeep) begin
            regMem[wr_addr] <= wr_data;
        end
    end

    // Read port 1: x0 override, then same-cycle writeback bypass, then storage.
    always_comb begin
        rs1_data = '0;
        if (state == READY) begin
            if ((ZERO_REG != 0) && (rs1_addr == '0)) begin
                rs1_data = '0;
            end else if (wrHits1) begin
                rs1_data = wr_data;
            end else begin
                rs1_data = regMem[rs1_addr];
            end
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rs2_data = '0;
        if (state == READY) begin
            if ((ZERO_REG != 0) && (rs2_addr == '0)) begin
                rs2_data = '0;
            end else if (wrHits2) begin
                rs2_data = wr_data;
            end else begin
                rs2_data = regMem[rs2_addr];
            end
        end
    end

    // Hazard outputs; a writeback in the same cycle releases the hazard immediately.
    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        if (state == READY) begin
            rs1_pending = pendingBits[rs1_addr] && !wrHits1;
            rs2_pending = pendingBits[rs2_addr] && !wrHits2;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb with x0-hardwired and plain instances
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            clear_req;
    logic            wr_en;
    logic            iss_en;
    logic            flush;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   iss_addr;
    logic [XLEN-1:0] wr_data;

    // index 1: ZERO_REG = 1 instance, index 0: ZERO_REG = 0 instance
    logic            rdy  [2];
    logic [XLEN-1:0] d1   [2];
    logic [XLEN-1:0] d2   [2];
    logic            p1   [2];
    logic            p2   [2];

    regfile_sb #(.XLEN(XLEN), .NUM_REGS(NR), .ZERO_REG(1)) u_dut_z (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .ready(rdy[1]),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(d1[1]), .rs2_data(d2[1]),
        .rs1_pending(p1[1]), .rs2_pending(p2[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
    );

    regfile_sb #(.XLEN(XLEN), .NUM_REGS(NR), .ZERO_REG(0)) u_dut_n (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .ready(rdy[0]),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(d1[0]), .rs2_data(d2[0]),
        .rs1_pending(p1[0]), .rs2_pending(p2[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
    );

    typedef struct {
        int                    cyc;
        logic                  rdy;
        logic [1:0][XLEN-1:0]  d1;
        logic [1:0][XLEN-1:0]  d2;
        logic [1:0]            p1;
        logic [1:0]            p2;
    } exp_t;

    exp_t expQ [$];

    int nCompared = 0;
    int nMismatch = 0;
    int cycNo     = 0;

    // Reference model: architectural contents, pending set, cycles left until ready.
    logic [XLEN-1:0] mMem  [2][NR];
    bit              mPend [2][NR];
    int              clearLeft;

    task automatic modelReset();
        clearLeft = NR;
        for (int v = 0; v < 2; v++) begin
            for (int r = 0; r < NR; r++) begin
                mMem[v][r]  = '0;
                mPend[v][r] = 1'b0;
            end
        end
    endtask

    function automatic logic [XLEN-1:0] expData(int v, logic [AW-1:0] a);
        if (clearLeft != 0) return '0;
        if (v == 1 && a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return mMem[v][a];
    endfunction

    function automatic logic expPend(int v, logic [AW-1:0] a);
        if (clearLeft != 0) return 1'b0;
        return mPend[v][a] && !(wr_en && wr_addr == a);
    endfunction

    task automatic modelEdge();
        if (clearLeft > 0) begin
            clearLeft--;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (wr_en && !(v == 1 && wr_addr == 0)) mMem[v][wr_addr] = wr_data;
            end
            if (clear_req) begin
                modelReset();
            end else begin
                for (int v = 0; v < 2; v++) begin
                    if (flush) begin
                        for (int r = 0; r < NR; r++) mPend[v][r] = 1'b0;
                    end
                    if (wr_en) mPend[v][wr_addr] = 1'b0;
                    if (iss_en && !(v == 1 && iss_addr == 0)) mPend[v][iss_addr] = 1'b1;
                end
            end
        end
    endtask

    // One bench cycle: push expectation for the current inputs, then advance the model on the edge.
    task automatic step();
        exp_t e;
        if (!reset_n) modelReset();
        e.cyc = cycNo;
        e.rdy = (clearLeft == 0);
        for (int v = 0; v < 2; v++) begin
            e.d1[v] = expData(v, rs1_addr);
            e.d2[v] = expData(v, rs2_addr);
            e.p1[v] = expPend(v, rs1_addr);
            e.p2[v] = expPend(v, rs2_addr);
        end
        expQ.push_back(e);
        @(posedge clk);
        if (reset_n) modelEdge();
        cycNo++;
        #1;
    endtask

    task automatic idle();
        clear_req = 1'b0;
        wr_en     = 1'b0;
        iss_en    = 1'b0;
        flush     = 1'b0;
        wr_addr   = '0;
        iss_addr  = '0;
        wr_data   = '0;
    endtask

    task automatic cmp(string nm, int cyc, logic [XLEN-1:0] act, logic [XLEN-1:0] exv);
        nCompared++;
        if (act !== exv) begin
            nMismatch++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exv);
        end
    endtask

    // Monitor: compare DUT outputs against each queued expectation mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            for (int v = 0; v < 2; v++) begin
                cmp(v ? "ready_z"  : "ready_n",  e.cyc, XLEN'(rdy[v]), XLEN'(e.rdy));
                cmp(v ? "rs1_data_z" : "rs1_data_n", e.cyc, d1[v], e.d1[v]);
                cmp(v ? "rs2_data_z" : "rs2_data_n", e.cyc, d2[v], e.d2[v]);
                cmp(v ? "rs1_pend_z" : "rs1_pend_n", e.cyc, XLEN'(p1[v]), XLEN'(e.p1[v]));
                cmp(v ? "rs2_pend_z" : "rs2_pend_n", e.cyc, XLEN'(p2[v]), XLEN'(e.p2[v]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        idle();
        modelReset();
        @(posedge clk);
        #1;
        repeat (3) step();
        reset_n = 1'b1;

        // Clear sweep after reset, then x1..x31 read back as zero.
        for (int i = 0; i < NR; i++) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'(NR - 1 - i);
            step();
        end
        for (int i = 1; i < NR; i += 2) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'((i + 1) % NR);
            step();
        end

        // Write with bypass, then read from storage.
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5; rs2_addr = 5;
        step();
        idle();
        step();

        // x0 write and issue.
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678; iss_en = 1'b1; iss_addr = 0;
        rs1_addr = 0; rs2_addr = 0;
        step();
        idle();
        step();

        // Issue/release hazard on x7.
        iss_en = 1'b1; iss_addr = 7; rs1_addr = 7; rs2_addr = 7;
        step();
        idle();
        step();
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
        step();
        iss_en = 1'b1; iss_addr = 7; wr_data = 32'h0BADF00D;
        step();
        idle();
        step();

        // Flush clears x3 and x9 pending; data untouched.
        iss_en = 1'b1; iss_addr = 3;
        step();
        iss_addr = 9; rs1_addr = 3; rs2_addr = 9;
        step();
        idle();
        flush = 1'b1;
        step();
        idle();
        step();

        // clear_req sweep with x4 written beforehand.
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h1; rs1_addr = 4; rs2_addr = 5;
        step();
        idle();
        clear_req = 1'b1;
        step();
        idle();
        repeat (NR + 2) step();

        // Reset in the middle of a sweep restarts it fully.
        clear_req = 1'b1;
        step();
        idle();
        repeat (10) step();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (NR + 2) step();

        // Randomized traffic with address locality to provoke hazards and bypass.
        for (int n = 0; n < 800; n++) begin
            rs1_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rs2_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wr_addr   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            iss_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wr_en     = ($urandom_range(0, 1) == 1);
            iss_en    = ($urandom_range(0, 1) == 1);
            wr_data   = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            clear_req = ($urandom_range(0, 99) == 0);
            reset_n   = ($urandom_range(0, 299) != 0);
            step();
        end
        reset_n = 1'b1;
        idle();
        step();

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL queue_drain actual=%0d expected=0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
